// File: rtl/pe_array_ctrl_if.sv
// Job-control and operand-buffer signals between the host, the PE array
// sequencer and the array's weight/activation buffers.
interface pe_array_ctrl_if #(
    parameter int NUM1   = 16,
    parameter int VLEN_W = 8
);
    localparam int AW = (NUM1 > 1) ? $clog2(NUM1) : 1;

    logic              start;
    logic [VLEN_W-1:0] vec_count;
    logic              busy;
    logic              done;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic              W_EN;
    logic              SELECTOR;
    logic              a_rd_en;
    logic [VLEN_W-1:0] a_rd_addr;
    logic              out_valid;
    logic [VLEN_W-1:0] out_addr;

    modport master (
        output start, vec_count,
        input  busy, done, w_rd_en, w_rd_addr, W_EN, SELECTOR,
        input  a_rd_en, a_rd_addr, out_valid, out_addr
    );

    modport slave (
        input  start, vec_count,
        output busy, done, w_rd_en, w_rd_addr, W_EN, SELECTOR,
        output a_rd_en, a_rd_addr, out_valid, out_addr
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a weight-stationary PE array: weight load, bank swap,
// activation streaming and tracking of valid bottom-row results.
module pe_array_ctrl #(
    parameter int NUM1   = 16,
    parameter int NUM2   = 16,
    parameter int VLEN_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    pe_array_ctrl_if.slave    bus
);
    localparam int AW  = (NUM1 > 1) ? $clog2(NUM1) : 1;
    localparam int WCW = $clog2(NUM1 + 1);
    localparam int LAT = NUM1 + NUM2;
    localparam int LCW = $clog2(LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SWAP,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [VLEN_W-1:0] vlen_q, vlen_d;
    logic [WCW-1:0]    w_cnt_q, w_cnt_d;
    logic [VLEN_W-1:0] s_cnt_q, s_cnt_d;
    logic              lat_run_q, lat_run_d;
    logic [LCW-1:0]    lat_cnt_q, lat_cnt_d;
    logic [VLEN_W-1:0] o_cnt_q, o_cnt_d;
    logic              sel_q, sel_d;

    logic w_fire;
    logic a_fire;
    logic o_fire;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            vlen_q    <= '0;
            w_cnt_q   <= '0;
            s_cnt_q   <= '0;
            lat_run_q <= 1'b0;
            lat_cnt_q <= '0;
            o_cnt_q   <= '0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vlen_q    <= vlen_d;
            w_cnt_q   <= w_cnt_d;
            s_cnt_q   <= s_cnt_d;
            lat_run_q <= lat_run_d;
            lat_cnt_q <= lat_cnt_d;
            o_cnt_q   <= o_cnt_d;
            sel_q     <= sel_d;
        end
    end

    assign w_fire = EN && (state_q == LOAD_W) && (w_cnt_q != WCW'(NUM1));
    assign a_fire = EN && (state_q == STREAM);
    // Results follow the first activation read by a fixed number of enabled
    // cycles, independent of the state machine, so they may overlap STREAM.
    assign o_fire = EN && lat_run_q && (lat_cnt_q == LCW'(LAT)) && (o_cnt_q != vlen_q);

    always_comb begin
        state_d   = state_q;
        vlen_d    = vlen_q;
        w_cnt_d   = w_cnt_q;
        s_cnt_d   = s_cnt_q;
        lat_run_d = lat_run_q;
        lat_cnt_d = lat_cnt_q;
        o_cnt_d   = o_cnt_q;
        sel_d     = sel_q;

        if (a_fire && (s_cnt_q == '0)) begin
            lat_run_d = 1'b1;
            lat_cnt_d = LCW'(1);
        end else if (EN && lat_run_q && (lat_cnt_q != LCW'(LAT))) begin
            lat_cnt_d = lat_cnt_q + LCW'(1);
        end
        if (o_fire) begin
            o_cnt_d = o_cnt_q + VLEN_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (EN && bus.start) begin
                    state_d   = LOAD_W;
                    vlen_d    = bus.vec_count;
                    w_cnt_d   = '0;
                    s_cnt_d   = '0;
                    lat_run_d = 1'b0;
                    lat_cnt_d = '0;
                    o_cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (EN) begin
                    if (w_cnt_q == WCW'(NUM1)) begin
                        state_d = SWAP;
                    end else begin
                        w_cnt_d = w_cnt_q + WCW'(1);
                    end
                end
            end
            SWAP: begin
                if (EN) begin
                    sel_d   = ~sel_q;
                    state_d = (vlen_q == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (EN) begin
                    s_cnt_d = s_cnt_q + VLEN_W'(1);
                    if (s_cnt_q == vlen_q - VLEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (o_fire && (o_cnt_q == vlen_q - VLEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (EN) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Deepest weight row is fetched first; W_EN trails the read by the
    // one-cycle buffer latency, so it is high for load cycles 1..NUM1.
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = EN && (state_q == DONE);
        bus.w_rd_en   = w_fire;
        bus.w_rd_addr = '0;
        if ((state_q == LOAD_W) && (w_cnt_q != WCW'(NUM1))) begin
            bus.w_rd_addr = AW'(NUM1 - 1) - AW'(w_cnt_q);
        end
        bus.W_EN      = EN && (state_q == LOAD_W) && (w_cnt_q != '0);
        bus.SELECTOR  = sel_q;
        bus.a_rd_en   = a_fire;
        bus.a_rd_addr = (state_q == STREAM) ? s_cnt_q : '0;
        bus.out_valid = o_fire;
        bus.out_addr  = o_cnt_q;
    end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl with a 4x4 array: per-cycle comparison of
// all outputs against the nominal job timeline.
module tb_pe_array_ctrl;
    localparam int N1 = 4;
    localparam int N2 = 4;
    localparam int VW = 8;

    logic clk;
    logic rst_n;
    logic en;
    int   err_count;
    int   check_count;

    pe_array_ctrl_if #(.NUM1(N1), .VLEN_W(VW)) bus ();

    pe_array_ctrl #(.NUM1(N1), .NUM2(N2), .VLEN_W(VW)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .EN    (en),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Packing: busy[24] done[23] w_rd_en[22] W_EN[21] SELECTOR[20] a_rd_en[19]
    // out_valid[18] w_rd_addr[17:16] a_rd_addr[15:8] out_addr[7:0]
    function automatic logic [31:0] expectedVec(input int e, input int v, input bit sel0);
        int s0 = N1 + 3;
        int o0 = s0 + N1 + N2;
        int dn = (v == 0) ? N1 + 3 : o0 + v;
        logic [31:0] r = '0;
        r[24] = (e >= 1) && (e <= dn);
        r[23] = (e == dn);
        if (e >= 1 && e <= N1) begin
            r[22] = 1'b1;
            r[17:16] = 2'(N1 - e);
        end
        r[21] = (e >= 2) && (e <= N1 + 1);
        r[20] = (e >= s0) ? ~sel0 : sel0;
        if (v > 0 && e >= s0 && e < s0 + v) begin
            r[19] = 1'b1;
            r[15:8] = 8'(e - s0);
        end
        if (v > 0 && e >= o0 && e < o0 + v) begin
            r[18] = 1'b1;
            r[7:0] = 8'(e - o0);
        end
        return r;
    endfunction

    function automatic logic [31:0] observedVec(input logic [31:0] ex, input bit full);
        logic [31:0] r = '0;
        r[24] = bus.busy;
        r[23] = bus.done;
        r[22] = bus.w_rd_en;
        r[21] = bus.W_EN;
        r[20] = bus.SELECTOR;
        r[19] = bus.a_rd_en;
        r[18] = bus.out_valid;
        if (full || ex[22]) r[17:16] = bus.w_rd_addr;
        if (full || ex[19]) r[15:8]  = bus.a_rd_addr;
        if (full || ex[18]) r[7:0]   = bus.out_addr;
        return r;
    endfunction

    // Runs one job from an idle cycle; a 3-cycle EN stall starts at stall_at
    // and a stray start is pulsed at extra_start_at (0 disables either).
    task automatic applyStimulus(input string name, input int v, input int stall_at,
                                 input int extra_start_at, input bit sel0);
        int dn = (v == 0) ? N1 + 3 : 2 * N1 + N2 + 3 + v;
        int e_next = 1;
        int cur;
        bit stalled;
        logic [31:0] ex;
        bus.start = 1'b1;
        bus.vec_count = VW'(v);
        for (int c = 1; c <= dn + 4; c++) begin
            @(posedge clk);
            #1;
            bus.start = (c == extra_start_at);
            if (c == 1) bus.vec_count = 8'hA5;
            stalled = (stall_at > 0) && (c >= stall_at) && (c < stall_at + 3);
            en = !stalled;
            cur = e_next;
            if (!stalled) e_next++;
            @(negedge clk);
            ex = expectedVec(cur, v, sel0);
            if (stalled) ex = ex & 32'h0110_0000;
            checkOutput($sformatf("%s c%0d", name, c), observedVec(ex, 1'b0), ex);
            if (cur == dn + 1) break;
        end
        en = 1'b1;
        bus.start = 1'b0;
    endtask

    initial begin
        err_count = 0;
        check_count = 0;
        rst_n = 1'b0;
        en = 1'b1;
        bus.start = 1'b0;
        bus.vec_count = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset", observedVec('0, 1'b1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle", observedVec('0, 1'b1), 32'h0);

        applyStimulus("basic", 3, 0, 0, 1'b0);
        applyStimulus("b2b1", 1, 0, 3, 1'b1);
        applyStimulus("b2b2", 1, 0, 0, 1'b0);
        applyStimulus("empty", 0, 0, 0, 1'b1);
        applyStimulus("stall", 3, 9, 0, 1'b0);
        applyStimulus("long", 20, 0, 0, 1'b1);
        applyStimulus("pre", 1, 0, 0, 1'b0);

        // Abort a job in the middle of the weight load.
        bus.start = 1'b1;
        bus.vec_count = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("abort loading", {31'b0, bus.w_rd_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort async", observedVec('0, 1'b1), 32'h0);
        @(negedge clk);
        checkOutput("abort held", observedVec('0, 1'b1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("post", 3, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
